// File: rtl/field_buf.sv
// field_buf: double-buffered Game-of-Life field store that self-loads a CONFIG_ID pattern.
// Define FIELD_BUF_LIVE_CNT_EN to add per-bank live-cell counters and the o_live_cnt output.
module field_buf #(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int CONFIG_ID = 0,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_reload,
    output logic          o_ready,
    input  logic [XW-1:0] i_eng_x_adr,
    input  logic [YW-1:0] i_eng_y_adr,
    output logic          o_eng_cell_state,
    input  logic [XW-1:0] i_disp_x_adr,
    input  logic [YW-1:0] i_disp_y_adr,
    output logic          o_disp_cell_state,
    input  logic          i_wr_en,
    input  logic [XW-1:0] i_wr_x_adr,
    input  logic [YW-1:0] i_wr_y_adr,
    input  logic          i_wr_state,
`ifdef FIELD_BUF_LIVE_CNT_EN
    output logic [$clog2(FIELD_W*FIELD_H+1)-1:0] o_live_cnt,
`endif
    input  logic          i_swap
);

    // i_wr_en and i_swap are single-cycle strobes qualified by o_ready; there is no
    // backpressure, so a strobe presented while o_ready=0 or together with i_reload is dropped.
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [YW-1:0]      row_q, row_d;
    logic               sel_q, sel_d;
    logic               ready_q, ready_d;
    logic               init_we, wr_ok, swap_ok;
    logic               wr_in, eng_in, disp_in;
    logic [FIELD_W-1:0] init_row;
    logic [FIELD_W-1:0] mem [2][FIELD_H];

    function automatic logic [FIELD_W-1:0] pattern_row(input logic [YW-1:0] y);
        logic [FIELD_W-1:0] r;
        int yi;
        r  = '0;
        yi = int'(y);
        case (CONFIG_ID)
            1: begin
                if (yi == 0) r[1] = 1'b1;
                else if (yi == 1) r[2] = 1'b1;
                else if (yi == 2) r[2:0] = 3'b111;
            end
            2: begin
                if (yi == FIELD_H / 2)
                    for (int x = FIELD_W / 2 - 1; x <= FIELD_W / 2 + 1; x++) r[x] = 1'b1;
            end
            3: begin
                for (int x = 0; x < FIELD_W; x++) r[x] = ((x + yi) % 2) == 1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign init_row = pattern_row(row_q);
    assign wr_in    = (int'(i_wr_x_adr) < FIELD_W) && (int'(i_wr_y_adr) < FIELD_H);
    assign eng_in   = (int'(i_eng_x_adr) < FIELD_W) && (int'(i_eng_y_adr) < FIELD_H);
    assign disp_in  = (int'(i_disp_x_adr) < FIELD_W) && (int'(i_disp_y_adr) < FIELD_H);
    assign o_ready  = ready_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (row_q == YW'(FIELD_H - 1)) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Reload overrides everything, including a row write already in progress.
        if (i_reload) begin
            state_d = ST_INIT;
            row_d   = '0;
            init_we = 1'b0;
        end
        wr_ok   = ready_q & ~i_reload & i_wr_en & wr_in;
        swap_ok = ready_q & ~i_reload & i_swap;
        sel_d   = sel_q ^ swap_ok;
        ready_d = (state_q == ST_RUN) & ~i_reload;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= ST_INIT;
            row_q             <= '0;
            sel_q             <= 1'b0;
            ready_q           <= 1'b0;
            o_eng_cell_state  <= 1'b0;
            o_disp_cell_state <= 1'b0;
        end else begin
            state_q           <= state_d;
            row_q             <= row_d;
            sel_q             <= sel_d;
            ready_q           <= ready_d;
            o_eng_cell_state  <= eng_in  ? mem[sel_q][i_eng_y_adr][i_eng_x_adr]   : 1'b0;
            o_disp_cell_state <= disp_in ? mem[sel_q][i_disp_y_adr][i_disp_x_adr] : 1'b0;
        end
    end

    // Storage has no reset; INIT rewrites every row of both banks.
    always_ff @(posedge i_clk) begin
        if (init_we) begin
            mem[sel_q][row_q]  <= init_row;
            mem[~sel_q][row_q] <= '0;
        end else if (wr_ok) begin
            mem[~sel_q][i_wr_y_adr][i_wr_x_adr] <= i_wr_state;
        end
    end

`ifdef FIELD_BUF_LIVE_CNT_EN
    localparam int CW = $clog2(FIELD_W * FIELD_H + 1);

    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          old_bit;

    function automatic logic [CW-1:0] row_pop(input logic [FIELD_W-1:0] r);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < FIELD_W; i++) c = c + CW'(r[i]);
        return c;
    endfunction

    always_comb begin
        cnt_d[0] = cnt_q[0];
        cnt_d[1] = cnt_q[1];
        old_bit  = mem[~sel_q][i_wr_y_adr][i_wr_x_adr];
        if (init_we) begin
            if (row_q == '0) cnt_d[sel_q] = row_pop(init_row);
            else             cnt_d[sel_q] = cnt_q[sel_q] + row_pop(init_row);
            cnt_d[~sel_q] = '0;
        end else if (wr_ok && (old_bit != i_wr_state)) begin
            if (i_wr_state) cnt_d[~sel_q] = cnt_q[~sel_q] + 1'b1;
            else            cnt_d[~sel_q] = cnt_q[~sel_q] - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            o_live_cnt <= '0;
        end else begin
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            o_live_cnt <= cnt_d[sel_d];
        end
    end
`endif

endmodule

// File: tb/tb_field_buf.sv
// Bench for field_buf: a 6x7 glider field checked every cycle against a bank-level model,
// plus a 4x4 checkerboard instance pinned with literal expectations.
module tb_field_buf;

    localparam int W   = 6;
    localparam int H   = 7;
    localparam int XW  = 3;
    localparam int YW  = 3;
    localparam int CW  = $clog2(W * H + 1);
    localparam int CW2 = $clog2(4 * 4 + 1);

    logic          clk, rst_n;
    logic          reload, ready, eng_c, disp_c, wr_en, wr_st, swap;
    logic [XW-1:0] eng_x, disp_x, wr_x;
    logic [YW-1:0] eng_y, disp_y, wr_y;
    logic          c_reload, c_ready, c_eng, c_disp, c_wr_en, c_wr_st, c_swap;
    logic [1:0]    c_x, c_y, c_wr_x, c_wr_y;
`ifdef FIELD_BUF_LIVE_CNT_EN
    logic [CW-1:0]  live;
    logic [CW2-1:0] c_live;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    field_buf #(.FIELD_W(W), .FIELD_H(H), .CONFIG_ID(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_reload(reload), .o_ready(ready),
        .i_eng_x_adr(eng_x), .i_eng_y_adr(eng_y), .o_eng_cell_state(eng_c),
        .i_disp_x_adr(disp_x), .i_disp_y_adr(disp_y), .o_disp_cell_state(disp_c),
        .i_wr_en(wr_en), .i_wr_x_adr(wr_x), .i_wr_y_adr(wr_y), .i_wr_state(wr_st),
`ifdef FIELD_BUF_LIVE_CNT_EN
        .o_live_cnt(live),
`endif
        .i_swap(swap)
    );

    field_buf #(.FIELD_W(4), .FIELD_H(4), .CONFIG_ID(3)) u_chk (
        .i_clk(clk), .i_rst_n(rst_n), .i_reload(c_reload), .o_ready(c_ready),
        .i_eng_x_adr(c_x), .i_eng_y_adr(c_y), .o_eng_cell_state(c_eng),
        .i_disp_x_adr(c_x), .i_disp_y_adr(c_y), .o_disp_cell_state(c_disp),
        .i_wr_en(c_wr_en), .i_wr_x_adr(c_wr_x), .i_wr_y_adr(c_wr_y), .i_wr_state(c_wr_st),
`ifdef FIELD_BUF_LIVE_CNT_EN
        .o_live_cnt(c_live),
`endif
        .i_swap(c_swap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: whole banks as flat arrays ----------------
    bit m_cur [W*H];
    bit m_nxt [W*H];
    int m_init_left;
    bit m_ready, m_known, e_valid, e_eng, e_disp;
    int e_live;

    function automatic bit glider(input int x, input int y);
        return (x == 1 && y == 0) || (x == 2 && y == 1) || (y == 2 && x <= 2);
    endfunction

    function automatic bit m_read(input int x, input int y);
        if (x >= W || y >= H) return 1'b0;
        return m_cur[y*W + x];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_known = 0; m_init_left = H;
            e_valid = 0; e_eng = 0; e_disp = 0; e_live = 0;
        end else begin
            e_valid = m_known;
            e_eng   = m_read(int'(eng_x), int'(eng_y));
            e_disp  = m_read(int'(disp_x), int'(disp_y));
            if (reload) begin
                m_ready = 0; m_known = 0; m_init_left = H;
            end else if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int i = 0; i < W*H; i++) begin
                        m_cur[i] = glider(i % W, i / W);
                        m_nxt[i] = 1'b0;
                    end
                    m_known = 1;
                end
            end else if (!m_ready) begin
                m_ready = 1;
            end else begin
                if (wr_en && int'(wr_x) < W && int'(wr_y) < H)
                    m_nxt[int'(wr_y)*W + int'(wr_x)] = wr_st;
                if (swap)
                    for (int i = 0; i < W*H; i++) begin
                        bit t;
                        t = m_cur[i]; m_cur[i] = m_nxt[i]; m_nxt[i] = t;
                    end
            end
            e_live = 0;
            for (int i = 0; i < W*H; i++) e_live += int'(m_cur[i]);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", ready, m_ready);
            if (e_valid) begin
                check("eng_read", eng_c, e_eng);
                check("disp_read", disp_c, e_disp);
            end
`ifdef FIELD_BUF_LIVE_CNT_EN
            if (m_known) check("live_cnt", live, e_live);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    bit sc [W*H];
    bit c_sc [16];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic read_cell(input int x, input int y, output bit e, output bit d);
        eng_x = XW'(x); eng_y = YW'(y); disp_x = XW'(x); disp_y = YW'(y);
        step();
        e = eng_c; d = disp_c;
    endtask

    task automatic write_cell(input int x, input int y, input bit v, input bit sw);
        wr_x = XW'(x); wr_y = YW'(y); wr_st = v; wr_en = 1'b1; swap = sw;
        step();
        wr_en = 1'b0; swap = 1'b0;
    endtask

    task automatic swap_pulse();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    task automatic scan_main(output int ones);
        ones = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                eng_x = XW'(x); eng_y = YW'(y);
                disp_x = XW'(W - 1 - x); disp_y = YW'(H - 1 - y);
                step();
                sc[y*W + x] = eng_c;
                ones += int'(eng_c);
            end
    endtask

    task automatic c_read(input int x, input int y, output bit e);
        c_x = 2'(x); c_y = 2'(y);
        step();
        e = c_eng;
    endtask

    task automatic c_write(input int x, input int y, input bit v);
        c_wr_x = 2'(x); c_wr_y = 2'(y); c_wr_st = v; c_wr_en = 1'b1;
        step();
        c_wr_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r_m, r_c, ones;
        bit e, d;
        rst_n = 0; reload = 0; wr_en = 0; wr_st = 0; swap = 0;
        eng_x = 0; eng_y = 0; disp_x = 0; disp_y = 0; wr_x = 0; wr_y = 0;
        c_reload = 0; c_wr_en = 0; c_wr_st = 0; c_swap = 0;
        c_x = 0; c_y = 0; c_wr_x = 0; c_wr_y = 0;
        repeat (2) step();
        check("rst_ready", ready, 0);
        check("rst_eng", eng_c, 0);
        check("rst_disp", disp_c, 0);
        check("rst_c_ready", c_ready, 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("rst_live", live, 0);
`endif

        rst_n = 1;
        r_m = 0; r_c = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready && r_m == 0) r_m = n;
            if (c_ready && r_c == 0) r_c = n;
            if (r_m != 0 && r_c != 0) break;
        end
        step();
        check("ready_latency", r_m, H + 1);
        check("c_ready_latency", r_c, 5);

        scan_main(ones);
        check("glider_ones", ones, 5);
        check("glider_1_0", sc[1], 1);
        check("glider_0_0", sc[0], 0);
        check("glider_2_2", sc[2*W + 2], 1);
        check("glider_0_1", sc[W], 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("glider_live", live, 5);
`endif

        ones = 0;
        for (int i = 0; i < 16; i++) begin
            c_read(i % 4, i / 4, e);
            c_sc[i] = e;
            ones += int'(e);
        end
        check("checker_ones", ones, 8);
        check("checker_1_0", c_sc[1], 1);
        check("checker_0_0", c_sc[0], 0);
        check("checker_3_2", c_sc[2*4 + 3], 1);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("checker_live", c_live, 8);
`endif
        c_write(1, 0, 1);
        c_write(1, 0, 1);
        c_write(0, 1, 1);
        c_write(0, 1, 0);
        c_swap = 1; step(); c_swap = 0;
        c_read(1, 0, e); check("c_swapped_1_0", e, 1);
        c_read(0, 1, e); check("c_swapped_0_1", e, 0);
        check("c_disp_agree", c_disp, 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("c_live_after_swap", c_live, 1);
`endif

        // write lands in the next bank only
        write_cell(3, 3, 1, 0);
        read_cell(3, 3, e, d);
        check("wr_hidden", e, 0);
        eng_x = 3; eng_y = 3;
        swap_pulse();
        check("swap_cycle_read", eng_c, 0);
        read_cell(3, 3, e, d);
        check("after_swap_eng", e, 1);
        check("after_swap_disp", d, 1);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("after_swap_live", live, 1);
`endif

        // write and swap in one cycle
        eng_x = 3; eng_y = 3;
        write_cell(4, 4, 1, 1);
        check("wr_swap_pre_data", eng_c, 1);
        read_cell(4, 4, e, d); check("wr_swap_4_4", e, 1);
        read_cell(3, 3, e, d); check("wr_swap_3_3", e, 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("wr_swap_live", live, 6);
`endif

        // out-of-range reads and writes
        read_cell(6, 2, e, d); check("oob_x_read", e, 0);
        read_cell(7, 0, e, d); check("oob_x7_read", e, 0);
        write_cell(1, 7, 1, 0);
        write_cell(6, 0, 1, 0);
        swap_pulse();
        scan_main(ones);
        check("oob_wr_dropped", ones, 1);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("oob_live", live, 1);
`endif

        // overwrite live cell with 1, then clear another
        write_cell(1, 0, 1, 0);
        write_cell(2, 1, 0, 0);
        swap_pulse();
        read_cell(2, 1, e, d); check("cleared_2_1", e, 0);
        read_cell(1, 0, e, d); check("kept_1_0", e, 1);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("overwrite_live", live, 5);
`endif
        swap_pulse();

        // reload with swap and write: reload wins
        wr_x = 5; wr_y = 5; wr_st = 1; wr_en = 1; swap = 1; reload = 1;
        r_m = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check("reload_ready_low", ready, 0);
                reload = 0; wr_en = 0; swap = 0;
            end else if (ready) begin
                r_m = n;
                break;
            end
        end
        step();
        check("reload_latency", r_m, H + 2);
        read_cell(1, 0, e, d); check("reload_pattern", e, 1);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("reload_live", live, 5);
`endif
        swap_pulse();
        scan_main(ones);
        check("reload_next_zero", ones, 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("reload_next_live", live, 0);
`endif

        // reset mid-INIT
        eng_x = 1; eng_y = 0; disp_x = 1; disp_y = 0;
        reload = 1; step(); reload = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midinit_rst_ready", ready, 0);
        check("midinit_rst_eng", eng_c, 0);
        check("midinit_rst_disp", disp_c, 0);
`ifdef FIELD_BUF_LIVE_CNT_EN
        check("midinit_rst_live", live, 0);
`endif
        step();
        rst_n = 1;
        r_m = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                r_m = n;
                break;
            end
        end
        step();
        check("rerun_latency", r_m, H + 1);
        read_cell(1, 0, e, d); check("rerun_pattern", e, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
